// File: rtl/fft_cbfp_reorder_buf_pkg.sv
// fft_cbfp_pkg: shared types, frame geometry and bit-reverse helper for the CBFP reorder buffer
package fft_cbfp_pkg;
  localparam int ARRAY_SIZE = 16;
  localparam int ARRAY_NUM = 4;
  localparam int DOUT_SIZE = 11;
  localparam int EXP_SIZE = 5;
  localparam int FRAME_PTS = 64;
  localparam int LOG2_FRAME = 6;
  typedef logic signed [DOUT_SIZE-1:0] sample_t;
  typedef logic [EXP_SIZE-1:0] exp_t;
  typedef logic [1:0] beat_idx_t;
  typedef sample_t [ARRAY_SIZE-1:0] beat_t;
  typedef exp_t [ARRAY_SIZE-1:0] lane_exp_t;
  typedef exp_t [ARRAY_NUM-1:0] frame_exp_t;
  typedef enum logic {RD_IDLE, RD_STREAM} rd_state_e;
  localparam beat_idx_t LAST_BEAT = beat_idx_t'(ARRAY_NUM - 1);
  function automatic logic [LOG2_FRAME-1:0] bitrev6(input logic [LOG2_FRAME-1:0] m);
    logic [LOG2_FRAME-1:0] r;
    for (int i = 0; i < LOG2_FRAME; i++) r[i] = m[LOG2_FRAME-1-i];
    return r;
  endfunction
endpackage

// File: rtl/fft_cbfp_reorder_buf_if.sv
// fft_cbfp_reorder_buf_if: input/output stream handshakes of the reorder buffer
interface fft_cbfp_reorder_buf_if;
  import fft_cbfp_pkg::*;
  logic valid_in, in_ready, valid_out, out_ready, frame_last, overflow;
  beat_t din, dout;
  frame_exp_t cal_cnt;
  lane_exp_t exp_out;
  modport slave (
    input valid_in, din, cal_cnt, out_ready,
    output in_ready, valid_out, dout, exp_out, frame_last, overflow
  );
  modport master (
    output valid_in, din, cal_cnt, out_ready,
    input in_ready, valid_out, dout, exp_out, frame_last, overflow
  );
endinterface

// File: rtl/fft_cbfp_reorder_buf_bank.sv
// fft_pingpong_bank: one frame of sample rows, its exponent latch and full flag
module fft_pingpong_bank
  import fft_cbfp_pkg::*;
(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wr_en_i,
  input  beat_idx_t             wr_row_i,
  input  beat_t                 wr_data_i,
  input  frame_exp_t            wr_exp_i,
  input  logic                  free_i,
  output logic                  full_o,
  output beat_t [ARRAY_NUM-1:0] mem_o,
  output frame_exp_t            exp_o
);
  beat_t [ARRAY_NUM-1:0] mem_q;
  frame_exp_t exp_q;
  logic full_q;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      mem_q <= '0;
      exp_q <= '0;
      full_q <= 1'b0;
    end else begin
      if (wr_en_i) mem_q[wr_row_i] <= wr_data_i;
      if (wr_en_i && wr_row_i == '0) exp_q <= wr_exp_i;
      if (wr_en_i && wr_row_i == LAST_BEAT) full_q <= 1'b1;
      else if (free_i) full_q <= 1'b0;
    end
  assign full_o = full_q;
  assign mem_o = mem_q;
  assign exp_o = exp_q;
endmodule

// File: rtl/fft_cbfp_reorder_buf.sv
// fft_cbfp_reorder_buf: ping-pong frame buffer replaying CBFP output in bit-reversed order
module fft_cbfp_reorder_buf
  import fft_cbfp_pkg::*;
(
  input logic clk,
  input logic rstn,
  fft_cbfp_reorder_buf_if.slave bus
);
  beat_t [ARRAY_NUM-1:0] mem [2];
  beat_t [ARRAY_NUM-1:0] view;
  frame_exp_t bank_exp [2];
  logic [1:0] full, avail, free;
  logic wr_ptr_q, rd_ptr_q, overflow_q, frame_last_q;
  logic wr_fire, wr_done, hs, last, sel_ptr, load;
  beat_idx_t wr_beat_q, rd_beat_q, sel_beat;
  rd_state_e state_q;
  beat_t dout_q, dout_d;
  lane_exp_t exp_out_q, exp_out_d;
  logic [LOG2_FRAME-1:0] r;
  assign bus.in_ready = !full[wr_ptr_q];
  assign wr_fire = bus.valid_in && bus.in_ready;
  assign wr_done = wr_fire && wr_beat_q == LAST_BEAT;
  assign hs = state_q == RD_STREAM && bus.out_ready;
  assign last = hs && rd_beat_q == LAST_BEAT;
  assign sel_ptr = rd_ptr_q ^ last;
  assign sel_beat = hs && !last ? rd_beat_q + beat_idx_t'(1) : '0;
  assign load = (hs && !last) || ((last || state_q == RD_IDLE) && avail[sel_ptr]);
  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign avail[b] = full[b] || (wr_done && wr_ptr_q == 1'(b));
    assign free[b] = last && rd_ptr_q == 1'(b);
    fft_pingpong_bank u_bank (
      .clk       (clk),
      .rstn      (rstn),
      .wr_en_i   (wr_fire && wr_ptr_q == 1'(b)),
      .wr_row_i  (wr_beat_q),
      .wr_data_i (bus.din),
      .wr_exp_i  (bus.cal_cnt),
      .free_i    (free[b]),
      .full_o    (full[b]),
      .mem_o     (mem[b]),
      .exp_o     (bank_exp[b])
    );
  end
  // a bank completing this cycle is read with its last row taken straight from din
  always_comb begin
    view = mem[sel_ptr];
    if (wr_fire && wr_ptr_q == sel_ptr) view[wr_beat_q] = bus.din;
    dout_d = '0;
    exp_out_d = '0;
    r = '0;
    for (int l = 0; l < ARRAY_SIZE; l++) begin
      r = bitrev6({sel_beat, 4'(l)});
      dout_d[l] = view[r[5:4]][r[3:0]];
      exp_out_d[l] = bank_exp[sel_ptr][r[5:4]];
    end
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      wr_ptr_q <= 1'b0;
      wr_beat_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_fire) wr_beat_q <= wr_beat_q + beat_idx_t'(1);
      if (wr_done) wr_ptr_q <= !wr_ptr_q;
      if (bus.valid_in && !bus.in_ready) overflow_q <= 1'b1;
    end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q <= RD_IDLE;
      rd_ptr_q <= 1'b0;
      rd_beat_q <= '0;
      dout_q <= '0;
      exp_out_q <= '0;
      frame_last_q <= 1'b0;
    end else begin
      if (last) rd_ptr_q <= !rd_ptr_q;
      if (load) begin
        state_q <= RD_STREAM;
        rd_beat_q <= sel_beat;
        dout_q <= dout_d;
        exp_out_q <= exp_out_d;
        frame_last_q <= sel_beat == LAST_BEAT;
      end else if (hs) begin
        state_q <= RD_IDLE;
        rd_beat_q <= '0;
        frame_last_q <= 1'b0;
      end
    end
  assign bus.valid_out = state_q == RD_STREAM;
  assign bus.dout = dout_q;
  assign bus.exp_out = exp_out_q;
  assign bus.frame_last = frame_last_q;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_fft_cbfp_reorder_buf.sv
// tb_fft_cbfp_reorder_buf: directed scoreboard bench for the bit-reversing reorder buffer
module tb_fft_cbfp_reorder_buf;
  import fft_cbfp_pkg::*;
  typedef struct {
    beat_t d;
    lane_exp_t e;
    logic last;
  } exp_beat_t;
  logic clk, rstn;
  fft_cbfp_reorder_buf_if bus ();
  fft_cbfp_reorder_buf dut (.clk(clk), .rstn(rstn), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int vectors = 0, miscompares = 0, n_out = 0, cyc = 0;
  int out_cyc[$];
  exp_beat_t sb[$];
  exp_beat_t it;
  sample_t ms [64];
  frame_exp_t me;
  int mb = 0;
  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  function automatic int brev(input int m);
    int r = 0;
    for (int i = 0; i < 6; i++) if (m[i]) r |= 1 << (5 - i);
    return r;
  endfunction
  function automatic sample_t samp(input int f, input int n);
    return (f == 0) ? sample_t'(n) : sample_t'(n * 5 + f * 97 - 300);
  endfunction
  function automatic exp_t ex(input int f, input int k);
    return exp_t'(f * 3 + k + 1);
  endfunction
  always @(posedge clk) cyc++;
  always @(negedge clk)
    if (bus.valid_out && bus.out_ready) begin
      check("unexpected_out", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        it = sb.pop_front();
        check("dout", bus.dout, it.d);
        check("exp_out", bus.exp_out, it.e);
        check("frame_last", bus.frame_last, it.last);
      end
      n_out++;
      out_cyc.push_back(cyc);
    end
  task automatic send_beat(input beat_t d, input frame_exp_t c, output logic acc);
    exp_beat_t x;
    int r;
    bus.valid_in = 1'b1;
    bus.din = d;
    bus.cal_cnt = c;
    @(negedge clk);
    acc = bus.in_ready;
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    if (acc) begin
      for (int l = 0; l < 16; l++) ms[mb * 16 + l] = d[l];
      if (mb == 0) me = c;
      if (mb == 3)
        for (int b = 0; b < 4; b++) begin
          for (int l = 0; l < 16; l++) begin
            r = brev(b * 16 + l);
            x.d[l] = ms[r];
            x.e[l] = me[r >> 4];
          end
          x.last = (b == 3);
          sb.push_back(x);
        end
      mb = (mb + 1) % 4;
    end
  endtask
  task automatic send_frame(input int f, input int gap, output int nacc);
    beat_t d;
    frame_exp_t c;
    logic acc;
    nacc = 0;
    for (int k = 0; k < 4; k++) begin
      for (int l = 0; l < 16; l++) d[l] = samp(f, k * 16 + l);
      c = frame_exp_t'($urandom);
      if (k == 0) for (int j = 0; j < 4; j++) c[j] = ex(f, j);
      send_beat(d, c, acc);
      if (acc) nacc++;
      for (int g = 0; g < gap; g++) begin
        bus.cal_cnt = frame_exp_t'($urandom);
        @(posedge clk);
        #1;
      end
    end
  endtask
  task automatic drain(input string tag);
    int i = 0;
    while (sb.size() != 0 && i < 300) begin
      @(posedge clk);
      i++;
    end
    #1;
    check(tag, sb.size(), 0);
  endtask
  int b0c[16] = '{0, 32, 16, 48, 8, 40, 24, 56, 4, 36, 20, 52, 12, 44, 28, 60};
  initial begin
    int n0, nacc;
    logic acc;
    beat_t b0, hold;
    rstn = 1'b0;
    bus.valid_in = 1'b0;
    bus.out_ready = 1'b1;
    bus.din = '0;
    bus.cal_cnt = '0;
    @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_valid_out", bus.valid_out, 1'b0);
    check("rst_frame_last", bus.frame_last, 1'b0);
    check("rst_overflow", bus.overflow, 1'b0);
    check("rst_dout", bus.dout, '0);
    check("rst_exp_out", bus.exp_out, '0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    // single frame, natural-index samples
    n0 = n_out;
    send_frame(0, 0, nacc);
    check("t1_accept", nacc, 4);
    check("t1_no_early_out", n_out, n0);
    check("t1_latency_valid", bus.valid_out, 1'b1);
    for (int l = 0; l < 16; l++) b0[l] = sample_t'(b0c[l]);
    check("t1_beat0_const", bus.dout, b0);
    drain("t1_drain");
    check("t1_beats", n_out - n0, 4);
    // eight frames back to back
    n0 = n_out;
    for (int f = 1; f <= 8; f++) begin
      send_frame(f, 0, nacc);
      check("t2_in_ready", nacc, 4);
    end
    drain("t2_drain");
    check("t2_beats", n_out - n0, 32);
    if (out_cyc.size() >= n0 + 32) check("t2_no_bubble", out_cyc[n0 + 31] - out_cyc[n0], 31);
    else check("t2_stamps", out_cyc.size(), n0 + 32);
    check("t2_overflow", bus.overflow, 1'b0);
    // backpressure with a third frame offered into full buffers
    n0 = n_out;
    bus.out_ready = 1'b0;
    send_frame(11, 0, nacc);
    check("t3_f1_accept", nacc, 4);
    hold = bus.dout;
    check("t3_valid_held", bus.valid_out, 1'b1);
    send_frame(12, 0, nacc);
    check("t3_f2_accept", nacc, 4);
    check("t3_in_ready_low", bus.in_ready, 1'b0);
    for (int l = 0; l < 16; l++) b0[l] = samp(13, l);
    send_beat(b0, '0, acc);
    check("t3_drop", acc, 1'b0);
    check("t3_overflow", bus.overflow, 1'b1);
    check("t3_hold_dout", bus.dout, hold);
    if (sb.size() != 0) check("t3_hold_expected", bus.dout, sb[0].d);
    repeat (11) @(posedge clk);
    #1;
    check("t3_hold_late", bus.dout, hold);
    bus.out_ready = 1'b1;
    drain("t3_drain");
    check("t3_beats", n_out - n0, 8);
    // gapped input, valid every third cycle
    n0 = n_out;
    send_frame(1, 2, nacc);
    send_frame(2, 2, nacc);
    drain("t4_drain");
    check("t4_beats", n_out - n0, 8);
    // asynchronous reset mid-output
    n0 = n_out;
    send_frame(20, 0, nacc);
    for (int i = 0; i < 50 && n_out < n0 + 2; i++) @(posedge clk);
    check("t5_reach_beat1", n_out >= n0 + 2, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    check("t5_valid_out", bus.valid_out, 1'b0);
    check("t5_in_ready", bus.in_ready, 1'b1);
    check("t5_overflow", bus.overflow, 1'b0);
    check("t5_frame_last", bus.frame_last, 1'b0);
    check("t5_dout", bus.dout, '0);
    check("t5_exp_out", bus.exp_out, '0);
    sb.delete();
    mb = 0;
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    repeat (5) @(posedge clk);
    #1;
    check("t5_no_out_after_rst", bus.valid_out, 1'b0);
    n0 = n_out;
    send_frame(21, 0, nacc);
    drain("t5_drain");
    check("t5_beats", n_out - n0, 4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fft_cbfp_reorder_buf.md
Name: fft_cbfp_reorder_buf

Overview:
- Stage directly downstream of the CBFP output shifter.
- Collects one 64-point frame: array_num beats of array_size lanes, 11-bit samples, plus one exponent (zero count) per beat.
- Stores the frame in a ping-pong buffer, then replays it in bit-reversed (natural-frequency) order with a per-lane exponent.
- Valid/ready handshakes on both sides decouple the stream from the next stage.

Parameters:
- array_size, 16, lanes per beat
- array_num, 4, beats per frame; frame = array_size*array_num = 64 points
- dout_size, 11, sample width (input and output)
- exp_size, 5, exponent width; the low exp_size bits of the shifter's cal_cnt

Ports:
- clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset
- valid_in  input  1  input beat valid
- in_ready  output  1  buffer can accept a beat
- din  input  signed [dout_size-1:0] x array_size  shifted samples, lane l = point beat*16+l
- cal_cnt  input  [exp_size-1:0] x array_num  frame exponents; entry k belongs to beat k; sampled on beat 0 of each frame
- valid_out  output  1  output beat valid
- out_ready  input  1  downstream accepts beat
- dout  output  signed [dout_size-1:0] x array_size  reordered samples
- exp_out  output  [exp_size-1:0] x array_size  exponent of each output lane
- frame_last  output  1  high with the final output beat of a frame
- overflow  output  1  sticky; a beat arrived while in_ready was low

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low (rstn).
- Reset values:
  - Both banks empty; all write and read counters 0.
  - in_ready=1, valid_out=0, frame_last=0, overflow=0.
  - dout and exp_out all 0.
  - A reset mid-frame discards partial and full banks. No output beat follows reset until a new complete frame has been written.
- Storage: two banks, each array_num x array_size samples plus array_num exponents. Banks are implemented as registers.
- Write side:
  - A beat is accepted on (valid_in && in_ready).
  - wr_beat counts 0..array_num-1. The beat is written to the current write bank at row wr_beat.
  - On wr_beat==0, cal_cnt[0..array_num-1] is latched into that bank's exponent store.
  - On wr_beat==array_num-1 the bank is marked full, wr_beat wraps to 0, and the write pointer toggles.
  - Input beats need not be consecutive.
- in_ready = the write bank is not full.
  - When both banks are full, in_ready=0.
  - valid_in while in_ready=0: beat dropped, overflow set (sticky until reset), counters unchanged.
- Read side:
  - Output index m = rd_beat*array_size + l; it takes stored point r = bitrev6(m). Bit-reverse is over log2(frame) bits.
  - dout[l] = bank[r/16][r%16]; exp_out[l] = bank_exp[r/16].
  - If the bank is written full at clock edge T and the output register is empty or being consumed, valid_out=1 from cycle T+1 with rd_beat=0.
  - The output is registered. When valid_out && !out_ready, dout, exp_out and frame_last hold stable.
  - The output advances one beat per handshake.
  - On the handshake of rd_beat==array_num-1: frame_last=1 on that beat; the bank is freed and the read pointer toggles.
  - If the other bank is full at that point, the next frame's beat 0 is presented in the next cycle with no bubble.
- Simultaneous events:
  - Write completing bank X in the same cycle read frees bank Y: both take effect; in_ready stays 1.
  - A bank freed at edge T is writable from cycle T+1.
- Throughput: with out_ready held high, one beat in and one beat out per cycle is sustained indefinitely.
- Frame latency: last input beat to first output beat is 1 cycle when the output is idle.
- Read FSM states:
  - IDLE (no full bank) -> STREAM (presenting beats).
  - STREAM -> STREAM on frame end if the other bank is full, otherwise -> IDLE.

Decomposition:
- Shared package fft_cbfp_pkg holds:
  - sample_t (signed dout_size) and exp_t (exp_size).
  - FRAME_PTS=64, LOG2_FRAME=6.
  - Function bitrev6.
- One sub-module: fft_pingpong_bank. It holds a single bank's storage, full flag and exponent latch, and is instantiated twice.
- Pointers, read FSM and output registers stay in the top.

Test Plan:
- Single frame, sample value = natural index n (0..63), cal_cnt={1,2,3,4}, out_ready=1:
  - valid_out rises 1 cycle after the 4th input beat.
  - Beat0 dout = {0,32,16,48,8,40,24,56,4,36,20,52,12,44,28,60}.
  - exp_out per lane = 1 + (bitrev6(m)>>4).
  - frame_last on beat 3.
- Back-to-back 8 frames, valid_in and out_ready held 1:
  - in_ready never drops, no bubbles on the output.
  - 32 output beats; overflow stays 0.
- Backpressure: out_ready=0 for 20 cycles while 3 frames are offered:
  - in_ready drops after frame 2 completes; the frame-1 beat0 outputs hold stable.
  - The frame-3 beat offered while in_ready=0 is dropped and overflow=1.
  - After release, frames 1 and 2 emerge intact.
- Gapped input, valid_in every third cycle:
  - Output identical to the contiguous case.
  - cal_cnt changes on non-beat-0 cycles are ignored.
- rstn pulsed low asynchronously mid-output, after beat 1 of a frame:
  - valid_out, in_ready=1, and all counters and outputs return to reset values immediately.
  - The next full frame reorders correctly starting from beat 0.
